// File: rtl/pwm_motor_pkg.sv
// Shared constants for the Avalon PWM motor controller.
// Register map word addresses and bit positions.
package pwm_motor_pkg;

    localparam int REG_CTRL      = 0;
    localparam int REG_PERIOD    = 1;
    localparam int REG_DIR       = 2;
    localparam int REG_STATUS    = 3;
    localparam int REG_DUTY_BASE = 4;

    localparam int CTRL_IRQ_EN_BIT = 31;
    localparam int STATUS_IRQ_BIT  = 0;
    localparam int STATUS_UPD_BIT  = 1;

endpackage

// File: rtl/pwm_motor_chan.sv
// One PWM channel: duty shadow, committed duty and comparator.
// The comparator output is registered, one clock behind cnt.
module pwm_motor_chan
    import pwm_motor_pkg::*;
#(
    parameter int PWM_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_duty,
    input  logic             commit,
    input  logic             en,
    input  logic [PWM_W-1:0] wdata,
    input  logic [PWM_W-1:0] cnt,
    output logic [PWM_W-1:0] duty_sh,
    output logic             pwm
);

    logic [PWM_W-1:0] duty_act;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_sh  <= '0;
            duty_act <= '0;
            pwm      <= 1'b0;
        end else begin
            if (wr_duty) duty_sh <= wdata;
            if (commit)  duty_act <= duty_sh;
            pwm <= en & (cnt < duty_act);
        end
    end

endmodule

// File: rtl/avalon_pwm_motor_ctrl.sv
// Avalon-MM slave driving NUM_CH PWM/direction motor channels.
// Period, duty and direction are double-buffered to period boundaries.
module avalon_pwm_motor_ctrl
    import pwm_motor_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int PWM_W  = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [NUM_CH-1:0] pwm_out,
    output logic [NUM_CH-1:0] dir_out,
    output logic              irq
);

    logic              wr;
    logic              wr_ctrl;
    logic              wr_per;
    logic              wr_dir;
    logic              wr_stat;
    logic [NUM_CH-1:0] wr_duty;
    logic              shadow_wr;
    logic              boundary;

    logic [NUM_CH-1:0] chan_en;
    logic              irq_en;
    logic [PWM_W-1:0]  per_sh;
    logic [PWM_W-1:0]  per_act;
    logic [PWM_W-1:0]  cnt;
    logic [NUM_CH-1:0] dir_sh;
    logic              irq_pending;
    logic              upd_pending;
    logic [PWM_W-1:0]  duty_sh [NUM_CH];
    logic              unused;

    assign wr      = chipselect & ~write_n;
    assign wr_ctrl = wr & (address == ADDR_W'(REG_CTRL));
    assign wr_per  = wr & (address == ADDR_W'(REG_PERIOD));
    assign wr_dir  = wr & (address == ADDR_W'(REG_DIR));
    assign wr_stat = wr & (address == ADDR_W'(REG_STATUS));

    assign shadow_wr = wr_per | wr_dir | (|wr_duty);
    assign boundary  = (cnt == per_act);
    assign irq       = irq_pending & irq_en;
    assign unused    = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chan_en     <= '0;
            irq_en      <= 1'b0;
            per_sh      <= '0;
            per_act     <= '0;
            cnt         <= '0;
            dir_sh      <= '0;
            dir_out     <= '0;
            irq_pending <= 1'b0;
            upd_pending <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                chan_en <= writedata[NUM_CH-1:0];
                irq_en  <= writedata[CTRL_IRQ_EN_BIT];
            end
            if (wr_per) per_sh <= writedata[PWM_W-1:0];
            if (wr_dir) dir_sh <= writedata[NUM_CH-1:0];
            // A boundary sets irq_pending even if software clears it now
            if (boundary) begin
                cnt         <= '0;
                per_act     <= per_sh;
                dir_out     <= dir_sh;
                irq_pending <= 1'b1;
                upd_pending <= shadow_wr;
            end else begin
                cnt         <= cnt + PWM_W'(1);
                upd_pending <= upd_pending | shadow_wr;
                if (wr_stat & writedata[STATUS_IRQ_BIT])
                    irq_pending <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        assign wr_duty[i] = wr & (address == ADDR_W'(REG_DUTY_BASE + i));

        pwm_motor_chan #(
            .PWM_W(PWM_W)
        ) u_chan (
            .clk     (clk),
            .reset_n (reset_n),
            .wr_duty (wr_duty[i]),
            .commit  (boundary),
            .en      (chan_en[i]),
            .wdata   (writedata[PWM_W-1:0]),
            .cnt     (cnt),
            .duty_sh (duty_sh[i]),
            .pwm     (pwm_out[i])
        );
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_W'(REG_CTRL): begin
                readdata[NUM_CH-1:0]      = chan_en;
                readdata[CTRL_IRQ_EN_BIT] = irq_en;
            end
            ADDR_W'(REG_PERIOD): readdata[PWM_W-1:0] = per_sh;
            ADDR_W'(REG_DIR):    readdata[NUM_CH-1:0] = dir_sh;
            ADDR_W'(REG_STATUS): begin
                readdata[STATUS_IRQ_BIT] = irq_pending;
                readdata[STATUS_UPD_BIT] = upd_pending;
            end
            default: ;
        endcase
        for (int i = 0; i < NUM_CH; i++) begin
            if (address == ADDR_W'(REG_DUTY_BASE + i))
                readdata[PWM_W-1:0] = duty_sh[i];
        end
    end

endmodule

// File: doc/avalon_pwm_motor_ctrl.md
Name: avalon_pwm_motor_ctrl

Overview:
- Avalon-MM slave driving NUM_CH motor channels. Each channel has a PWM output and a direction output.
- Successor to the single-register motor PIO: the same bus-write interface with combinational readdata, generalised to N channels.
- Adds a shared period counter, per-channel duty, double-buffered period/duty/direction registers committed at period boundaries, instant per-channel enable, and a period-end interrupt.
- Sits between the NIOS data master and the H-bridge driver pins.

Parameters:
- NUM_CH, 4, number of motor channels (1..16).
- PWM_W, 16, width of the period counter, period and duty registers (2..31).
- ADDR_W, 3, address width. Must satisfy 2^ADDR_W >= 4+NUM_CH.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  ADDR_W  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address.
- pwm_out  out  NUM_CH  per-channel PWM, registered.
- dir_out  out  NUM_CH  per-channel direction, registered.
- irq  out  1  level interrupt: irq_pending & irq_en.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous, active-low, on reset_n. All state is reset to 0 on reset_n low: registers, counter, pwm_out=0, dir_out=0, irq=0. Reset mid-period aborts the period immediately.
- Write strobe: wr = chipselect & ~write_n. A write takes effect at the clock edge.
- Reads: combinational, zero wait states, no read side effects. Unused bits read 0.
- Register map:
  - 0 CTRL: [NUM_CH-1:0] chan_en (live, not buffered); [31] irq_en.
  - 1 PERIOD: shadow period [PWM_W-1:0].
  - 2 DIR: shadow dir [NUM_CH-1:0].
  - 3 STATUS: [0] irq_pending (write 1 clears); [1] upd_pending (read-only).
  - 4+i DUTY[i]: shadow duty [PWM_W-1:0].
  - Other addresses: writes ignored, reads return 0.
  - PERIOD, DIR and DUTY read back their shadow values.
- Counter:
  - cnt runs 0..per_act and wraps to 0. The boundary is cnt==per_act.
  - The PWM period is per_act+1 clocks.
  - per_act=0: every cycle is a boundary and cnt stays 0.
- At each boundary, in the same edge as the wrap:
  - per_act <= shadow period; duty_act[i] <= shadow duty[i]; dir_out <= shadow dir.
  - Shadow values used are those registered before that edge. A shadow write in the boundary cycle commits at the next boundary.
  - upd_pending <= 0, unless a shadow write occurs in that cycle, in which case it is 1.
  - irq_pending <= 1 every boundary, regardless of irq_en.
- upd_pending is set by any write to PERIOD, DIR or DUTY.
- Simultaneous boundary and STATUS write-1-clear: set wins, irq_pending stays 1.
- PWM output:
  - pwm_out[i] <= chan_en[i] & (cnt < duty_act[i]). This is one clock of latency from cnt.
  - duty_act >= per_act+1 gives 100%; duty 0 gives 0%.
  - Clearing chan_en[i] forces pwm_out[i]=0 at the next edge, independent of the boundary (emergency stop).
  - Setting chan_en[i] takes effect the same way, mid-period.
- After reset, nothing is active until software writes shadows and waits for a boundary. The first boundary is at cycle 0, since per_act=0, so shadows commit at the first clock after their write.
- Arithmetic: unsigned, PWM_W-bit comparisons. writedata is truncated to the register width.

Decomposition:
- Shared package pwm_motor_pkg holds:
  - register address constants: REG_CTRL=0, REG_PERIOD=1, REG_DIR=2, REG_STATUS=3, REG_DUTY_BASE=4;
  - the CTRL_IRQ_EN_BIT=31 constant;
  - STATUS bit indices.
- One natural sub-module: pwm_motor_chan, instantiated NUM_CH times. It holds the duty shadow, duty_act and the comparator, and drives pwm_out[i].
- Top level holds: bus decode, CTRL/PERIOD/DIR/STATUS registers, counter, boundary logic, read mux.

Test Plan:
- Reset values: assert reset_n=0 mid-run. pwm_out, dir_out, irq and cnt are 0 immediately, without waiting for a clock edge. All readbacks return 0 after release.
- Basic PWM: PERIOD=9, DUTY0=3, CTRL=1, then wait for the boundary. pwm_out[0] is high 3 of every 10 clocks and other channels stay 0. Readback of address 4 returns 3.
- Double buffering: while running PERIOD=9/DUTY0=3, write DUTY0=7 mid-period. The current period keeps 3-high and the next period is 7-high. upd_pending is 1 until the boundary, then 0. DIR=1 written mid-period appears on dir_out[0] only at the boundary.
- Duty extremes: DUTY0=0 gives constant 0. DUTY0=10 or DUTY0=0xFFFF with PERIOD=9 gives constant 1. PERIOD=0 with DUTY0=1 gives constant 1.
- Emergency stop: with DUTY0=7, write CTRL=0 at cnt=2. pwm_out[0]=0 one clock later and stays 0 for the rest of the period.
- IRQ: CTRL=0x80000000, PERIOD=4. irq rises after the boundary. Writing STATUS=1 in a non-boundary cycle clears it. Writing STATUS=1 exactly at a boundary cycle leaves irq_pending=1. Write to address 7 with NUM_CH=3 is ignored and reads 0.
